// File: rtl/ads1672_acq_ctrl_if.sv
// Output sample stream of the ADS1672 acquisition controller.
// Single-entry valid/ready channel; master drives valid/data, slave drives ready.
interface ads1672_acq_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/ads1672_acq_ctrl.sv
// ADS1672 acquisition controller: START pin sequencing, DRDY watch, read requests,
// settling discard, sample counting and a single-entry output register.
module ads1672_acq_ctrl #(
    parameter int unsigned DATA_WIDTH       = 24,
    parameter int unsigned COUNT_WIDTH      = 16,
    parameter int unsigned START_LOW_CYCLES = 8,
    parameter int unsigned DRDY_TIMEOUT     = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_start,
    input  logic                   cmd_stop,
    input  logic [COUNT_WIDTH-1:0] cfg_num_samples,
    input  logic [3:0]             cfg_discard,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   overflow_err,
    output logic                   adc_start,
    input  logic                   adc_drdy_n,
    output logic                   rd_req,
    input  logic                   rd_done,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    ads1672_acq_ctrl_if.master     m_if
);

    localparam int unsigned SL_W = (START_LOW_CYCLES > 1) ? $clog2(START_LOW_CYCLES) : 1;
    localparam int unsigned TO_W = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT + 1) : 1;
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(START_LOW_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRDY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_LOW = 2'd1,
        S_WAIT_DRDY = 2'd2,
        S_READ      = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SL_W-1:0]        sl_cnt_q, sl_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [COUNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
    logic [COUNT_WIDTH-1:0] num_q, num_d;
    logic [3:0]             disc_cnt_q, disc_cnt_d;
    logic [3:0]             disc_q, disc_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   timeout_d, overflow_d;
    logic                   mval_q, mval_d;
    logic [DATA_WIDTH-1:0]  mdata_q, mdata_d;
    logic                   busy_d, done_d, adc_start_d, rd_req_d;
    logic                   offer;

    // DRDY synchronizer plus history flop for falling-edge detection
    logic drdy_s1, drdy_s2, drdy_hist;
    logic drdy_fall;
    assign drdy_fall = !drdy_s2 && drdy_hist;

    // Next-state, counters and output-register logic
    always_comb begin
        state_d     = state_q;
        sl_cnt_d    = sl_cnt_q;
        to_cnt_d    = to_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        num_d       = num_q;
        disc_cnt_d  = disc_cnt_q;
        disc_d      = disc_q;
        stop_pend_d = stop_pend_q;
        timeout_d   = timeout_err;
        overflow_d  = overflow_err;
        mval_d      = mval_q;
        mdata_d     = mdata_q;
        rd_req_d    = 1'b0;
        offer       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    num_d       = cfg_num_samples;
                    disc_d      = cfg_discard;
                    timeout_d   = 1'b0;
                    overflow_d  = 1'b0;
                    smp_cnt_d   = '0;
                    disc_cnt_d  = '0;
                    sl_cnt_d    = '0;
                    stop_pend_d = 1'b0;
                    state_d     = S_START_LOW;
                end
            end
            S_START_LOW: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (sl_cnt_q == SL_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DRDY;
                end else begin
                    sl_cnt_d = sl_cnt_q + SL_W'(1);
                end
            end
            S_WAIT_DRDY: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (drdy_fall) begin
                    rd_req_d    = 1'b1;
                    to_cnt_d    = '0;
                    stop_pend_d = 1'b0;
                    state_d     = S_READ;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_READ: begin
                if (cmd_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (rd_done) begin
                    to_cnt_d = '0;
                    if (stop_pend_q || cmd_stop) begin
                        // Sample in flight at abort is neither output nor counted
                        state_d = S_IDLE;
                    end else if (disc_cnt_q < disc_q) begin
                        disc_cnt_d = disc_cnt_q + 4'd1;
                        state_d    = S_WAIT_DRDY;
                    end else begin
                        smp_cnt_d = smp_cnt_q + COUNT_WIDTH'(1);
                        offer     = 1'b1;
                        if ((num_q != '0) && (smp_cnt_d == num_q)) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_DRDY;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mval_q && m_if.m_ready) begin
            mval_d = 1'b0;
        end
        // A full, unconsumed register drops the new sample but it still counts
        if (offer) begin
            if (!mval_q || m_if.m_ready) begin
                mval_d  = 1'b1;
                mdata_d = rd_data;
            end else begin
                overflow_d = 1'b1;
            end
        end

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
        adc_start_d = (state_d == S_WAIT_DRDY) || (state_d == S_READ);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sl_cnt_q     <= '0;
            to_cnt_q     <= '0;
            smp_cnt_q    <= '0;
            num_q        <= '0;
            disc_cnt_q   <= '0;
            disc_q       <= '0;
            stop_pend_q  <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            mval_q       <= 1'b0;
            mdata_q      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            adc_start    <= 1'b0;
            rd_req       <= 1'b0;
            drdy_s1      <= 1'b1;
            drdy_s2      <= 1'b1;
            drdy_hist    <= 1'b1;
        end else begin
            state_q      <= state_d;
            sl_cnt_q     <= sl_cnt_d;
            to_cnt_q     <= to_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            num_q        <= num_d;
            disc_cnt_q   <= disc_cnt_d;
            disc_q       <= disc_d;
            stop_pend_q  <= stop_pend_d;
            timeout_err  <= timeout_d;
            overflow_err <= overflow_d;
            mval_q       <= mval_d;
            mdata_q      <= mdata_d;
            busy         <= busy_d;
            done         <= done_d;
            adc_start    <= adc_start_d;
            rd_req       <= rd_req_d;
            drdy_s1      <= adc_drdy_n;
            drdy_s2      <= drdy_s1;
            drdy_hist    <= drdy_s2;
        end
    end

    assign m_if.m_valid = mval_q;
    assign m_if.m_data  = mdata_q;

endmodule

// File: doc/ads1672_acq_ctrl.md
# ads1672_acq_ctrl

Acquisition controller for the ADS1672 ADC. It takes start/stop commands and a sample-count configuration from the host register block, drives the converter START pin, and watches the data-ready line. For each conversion it requests a 24-bit read from the serial read engine and pushes the results into a single-entry valid/ready output stream. It also reports completion, DRDY timeout and output overflow.

## Interface
Parameters:
- DATA_WIDTH, 24, ADC word width
- COUNT_WIDTH, 16, sample counter width
- START_LOW_CYCLES, 8, cycles START is held low before each acquisition (converter resync)
- DRDY_TIMEOUT, 65535, max cycles in WAIT_DRDY before timeout error

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cmd_start  in  1  one-cycle pulse: begin acquisition
- cmd_stop  in  1  one-cycle pulse: abort acquisition
- cfg_num_samples  in  COUNT_WIDTH  samples to acquire; 0 = continuous; latched on accepted cmd_start
- cfg_discard  in  4  leading samples to discard for settling; latched on accepted cmd_start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on every return to IDLE
- timeout_err  out  1  sticky; cleared by accepted cmd_start
- overflow_err  out  1  sticky; cleared by accepted cmd_start
- adc_start  out  1  ADS1672 START pin
- adc_drdy_n  in  1  ADS1672 DRDY, asynchronous, active-low
- rd_req  out  1  one-cycle pulse to serial read engine
- rd_done  in  1  one-cycle pulse; rd_data valid in the same cycle
- rd_data  in  DATA_WIDTH  sample from read engine
- m_valid  out  1  output sample valid
- m_data  out  DATA_WIDTH  output sample
- m_ready  in  1  downstream accepts when m_valid && m_ready

## Operation
- Reset values: all outputs are 0. State is IDLE. All counters are 0.
- adc_drdy_n passes through a 2-flop synchronizer plus a history flop. drdy_fall = synced low && history high.
- States:
  - IDLE: adc_start=0. On cmd_start with cmd_stop low: latch the cfg inputs, clear both error flags, clear the sample and discard counters, then go to START_LOW.
  - START_LOW: adc_start=0 for START_LOW_CYCLES cycles, then go to WAIT_DRDY.
  - WAIT_DRDY: adc_start=1. The timeout counter increments each cycle.
    - On drdy_fall: pulse rd_req, reset the timeout counter, go to READ.
    - When the counter reaches DRDY_TIMEOUT: set timeout_err and go to IDLE.
  - READ: adc_start=1. Wait for rd_done.
    - While the discard counter is below the latched cfg_discard: increment the discard counter and drop the sample. Dropped samples are not counted.
    - Otherwise: increment the sample counter and offer rd_data to the output register.
    - If the latched count is nonzero and the sample counter now equals it, go to IDLE. Otherwise go to WAIT_DRDY.
- Output register:
  - Loads rd_data and sets m_valid when it is empty, or when it is being consumed (m_valid && m_ready) in the same cycle.
  - Otherwise the new sample is dropped and overflow_err is set. The dropped sample still counts toward cfg_num_samples.
  - m_valid clears on handshake. Contents persist across IDLE and across a new cmd_start.
- drdy_fall outside WAIT_DRDY is ignored. It is not counted.
- cmd_stop in START_LOW or WAIT_DRDY: go to IDLE on the next edge.
- cmd_stop in READ: remembered, and honoured on rd_done. That sample is discarded and not counted, then the block goes to IDLE.
- cmd_start while busy: ignored. cmd_start and cmd_stop together in IDLE: nothing happens.
- Counters saturate-free at COUNT_WIDTH. In continuous mode the sample counter wraps modulo 2^COUNT_WIDTH and never terminates.

## Timing
- cmd_start at edge N: busy=1 and adc_start=0 from N+1. adc_start=1 from N+1+START_LOW_CYCLES.
- adc_drdy_n falls before edge K (in WAIT_DRDY): rd_req=1 for exactly the cycle after edge K+2.
- rd_done at edge R (sample accepted): m_valid=1 and m_data=rd_data from R+1. State transition at R+1.
- Terminal rd_done at edge R: done=1 for one cycle after R, busy=0 and adc_start=0 from R+1.
- Timeout: WAIT_DRDY entered at edge W with no drdy_fall → timeout_err=1, done=1, busy=0 after edge W+DRDY_TIMEOUT.
- Reset mid-operation: all outputs are 0 after the next edge. Any pending rd_done is ignored.

## Test plan
- Basic: num_samples=3, discard=0, m_ready=1, 3 DRDY falls with rd_data 0x123456/0xABCDEF/0x000001 → 3 m_valid beats carrying those values in order, one done pulse, adc_start low after the third.
- Discard: num_samples=2, discard=2, 4 conversions A,B,C,D → only C and D are output.
- Overflow: m_ready=0, 2 conversions → m_data=first sample, overflow_err=1. Raise m_ready → first sample delivered, done after the 2nd conversion. Simultaneous rd_done with handshake → no overflow.
- Timeout: DRDY_TIMEOUT=100, no DRDY fall → timeout_err=1 and done exactly 100 cycles after WAIT_DRDY entry. Next cmd_start clears timeout_err.
- Stop during READ: cmd_stop between rd_req and rd_done in continuous mode → that sample not output, done on the cycle after rd_done.
- Reset mid-READ: rst asserted with rd_done pending → all outputs 0. A later rd_done produces no m_valid.
